// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl -- debounced run/pause/single-step control and the divided CPU clock.
// Revision 1.0
`default_nettype none

module cpu_clock_ctrl_debounce #(
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic CLK_undiv,
  input  logic RESET,
  input  logic btn_raw,
  output logic press_evt
);

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic                     stable_q, stable_d;
  logic                     stable_dly_q, stable_dly_d;
  logic                     press_q, press_d;
  logic [DEBOUNCE_BITS-1:0] filt_q, filt_d;

  // The filter only accepts a new level after it has been seen on every one
  // of 2^DEBOUNCE_BITS consecutive samples; any agreement restarts the count.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    filt_d       = '0;
    if (sync2_q != stable_q) begin
      if (filt_q == {DEBOUNCE_BITS{1'b1}}) begin
        stable_d = sync2_q;
      end else begin
        filt_d = filt_q + DEBOUNCE_BITS'(1);
      end
    end
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge CLK_undiv or posedge RESET) begin
    if (RESET) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      filt_q       <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      filt_q       <= filt_d;
    end
  end

  assign press_evt = press_q;

endmodule

module cpu_clock_ctrl #(
  parameter int CLK_DIV_BITS  = 25,
  parameter int DEBOUNCE_BITS = 20,
  parameter int START_PAUSED  = 0
) (
  input  logic        CLK_undiv,
  input  logic        RESET,
  input  logic        BTN_PAUSE,
  input  logic        BTN_STEP,
  output logic        CLK_CPU,
  output logic        CPU_TICK,
  output logic        PAUSED,
  output logic [31:0] CYCLE_COUNT
);

  localparam int CW = CLK_DIV_BITS + 1;
  localparam logic [CW-1:0] CNT_ONES = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_HALF = {1'b0, {CLK_DIV_BITS{1'b1}}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = (START_PAUSED != 0) ? ST_PAUSED : ST_RUN;

  logic [1:0] btn_raw;
  logic [1:0] press_evt;
  logic       pause_evt;
  logic       step_evt;

  assign btn_raw   = {BTN_STEP, BTN_PAUSE};
  assign pause_evt = press_evt[0];
  assign step_evt  = press_evt[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      cpu_clock_ctrl_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS)
      ) u_debounce (
        .CLK_undiv (CLK_undiv),
        .RESET     (RESET),
        .btn_raw   (btn_raw[gi]),
        .press_evt (press_evt[gi])
      );
    end
  endgenerate

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            paused_q, paused_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic            counting;
  logic            wrap;

  always_comb begin
    state_d       = state_q;
    counting      = (state_q != ST_PAUSED);
    wrap          = counting && (cnt_q == CNT_ONES);
    cnt_d         = counting ? (cnt_q + CW'(1)) : '0;
    // The tick is registered on the same edge that sets the clock MSB.
    tick_d        = counting && (cnt_q == CNT_HALF);
    cycle_count_d = tick_d ? (cycle_count_q + 32'd1) : cycle_count_q;

    // A pause press always outranks a step press or a period wrap.
    case (state_q)
      ST_RUN: begin
        if (pause_evt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pause_evt)  state_d = ST_RUN;
        else if (wrap)  state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (pause_evt)      state_d = ST_RUN;
        else if (step_evt)  state_d = ST_STEP;
      end
      ST_STEP: begin
        if (pause_evt)  state_d = ST_RUN;
        else if (wrap)  state_d = ST_PAUSED;
      end
      default: state_d = RESET_STATE;
    endcase

    paused_d = (state_d == ST_PAUSED);
  end

  always_ff @(posedge CLK_undiv or posedge RESET) begin
    if (RESET) begin
      state_q       <= RESET_STATE;
      cnt_q         <= '0;
      tick_q        <= 1'b0;
      paused_q      <= (RESET_STATE == ST_PAUSED);
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      paused_q      <= paused_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign CLK_CPU     = cnt_q[CW-1];
  assign CPU_TICK    = tick_q;
  assign PAUSED      = paused_q;
  assign CYCLE_COUNT = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl -- scoreboard bench: expected ticks queued by stimulus, popped by a tick monitor.
// Revision 1.0
`default_nettype none

module tb_cpu_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_pause = 1'b0;
  logic        btn_step = 1'b0;
  logic        clk_cpu;
  logic        cpu_tick;
  logic        paused;
  logic [31:0] cycle_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int at_cyc;
    int count;
  } tick_t;

  tick_t exp_q[$];

  cpu_clock_ctrl #(
    .CLK_DIV_BITS  (2),
    .DEBOUNCE_BITS (4),
    .START_PAUSED  (0)
  ) dut (
    .CLK_undiv   (clk),
    .RESET       (rst),
    .BTN_PAUSE   (btn_pause),
    .BTN_STEP    (btn_step),
    .CLK_CPU     (clk_cpu),
    .CPU_TICK    (cpu_tick),
    .PAUSED      (paused),
    .CYCLE_COUNT (cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_ticks(input int first, input int count0, input int n);
    for (int i = 0; i < n; i++) begin
      tick_t e;
      e.at_cyc = first + 8 * i;
      e.count  = count0 + i;
      exp_q.push_back(e);
    end
  endtask

  // Tick monitor: every CPU_TICK must match the head of the expectation queue.
  always @(negedge clk) begin
    if (cpu_tick) begin
      if (exp_q.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_tick: got tick with count %0d, expected none (cycle %0d)",
                 cycle_count, cyc);
      end else begin
        tick_t e;
        e = exp_q.pop_front();
        chk("tick_cycle", cyc, e.at_cyc);
        chk("tick_count", cycle_count, e.count);
        chk("tick_clk_cpu", clk_cpu, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int r, p, s, s2, r2, q, hi;

    // Reset state
    wait_cyc(1);
    chk("rst_clk_cpu", clk_cpu, 0);
    chk("rst_tick", cpu_tick, 0);
    chk("rst_paused", paused, 0);
    chk("rst_count", cycle_count, 0);
    wait_cyc(3);
    rst = 1'b0;
    r = cyc;

    // Free run; bounce rejection; clean pause at cnt=5 (ticks up to the drain).
    push_ticks(r + 4, 1, 28);
    wait_cyc(r + 80);
    chk("run_count_80", cycle_count, 10);
    for (int i = 0; i < 5; i++) begin
      wait_cyc(r + 80 + 20 * i);
      btn_pause = 1'b1;
      wait_cyc(r + 90 + 20 * i);
      btn_pause = 1'b0;
    end
    wait_cyc(r + 196);
    chk("bounce_paused", paused, 0);

    p = r + 197;
    wait_cyc(p);
    btn_pause = 1'b1;
    wait_cyc(p + 26);
    chk("drain_paused_early", paused, 0);
    wait_cyc(p + 27);
    chk("drain_paused", paused, 1);
    chk("drain_clk_cpu", clk_cpu, 0);
    chk("drain_count", cycle_count, 28);
    chk("drain_pending", exp_q.size(), 0);
    wait_cyc(p + 40);
    btn_pause = 1'b0;
    wait_cyc(p + 60);
    chk("frozen_count", cycle_count, 28);
    chk("frozen_clk_cpu", clk_cpu, 0);

    // Single step with the step button held across the whole period.
    s = p + 70;
    push_ticks(s + 24, 29, 1);
    wait_cyc(s);
    btn_step = 1'b1;
    wait_cyc(s + 19);
    chk("step_paused_before", paused, 1);
    hi = 0;
    for (int t = s + 20; t <= s + 30; t++) begin
      wait_cyc(t);
      hi += int'(clk_cpu);
      if (t == s + 20) chk("step_left_paused", paused, 0);
      if (t == s + 28) chk("step_back_paused", paused, 1);
    end
    chk("step_high_cycles", hi, 4);
    wait_cyc(s + 40);
    btn_step = 1'b0;
    wait_cyc(s + 70);
    chk("step_paused_after", paused, 1);
    chk("step_count", cycle_count, 29);
    chk("step_pending", exp_q.size(), 0);

    // Reset in the middle of a step at cnt=6.
    s2 = s + 80;
    push_ticks(s2 + 24, 30, 1);
    wait_cyc(s2);
    btn_step = 1'b1;
    wait_cyc(s2 + 22);
    btn_step = 1'b0;
    wait_cyc(s2 + 26);
    chk("midstep_clk_cpu", clk_cpu, 1);
    chk("midstep_count", cycle_count, 30);
    rst = 1'b1;
    #1;
    chk("async_clk_cpu", clk_cpu, 0);
    chk("async_count", cycle_count, 0);
    chk("async_paused", paused, 0);
    wait_cyc(s2 + 28);
    rst = 1'b0;
    r2 = cyc;
    push_ticks(r2 + 4, 1, 4);
    wait_cyc(r2 + 1);
    chk("rerun_paused", paused, 0);

    // Pause again so the simultaneous-press case starts from PAUSED.
    wait_cyc(r2 + 5);
    btn_pause = 1'b1;
    wait_cyc(r2 + 31);
    chk("repause_early", paused, 0);
    wait_cyc(r2 + 32);
    chk("repause_paused", paused, 1);
    chk("repause_count", cycle_count, 4);
    wait_cyc(r2 + 40);
    btn_pause = 1'b0;

    // Simultaneous pause+step: pause wins, then a step press in RUN is ignored.
    q = r2 + 70;
    push_ticks(q + 24, 5, 15);
    wait_cyc(q);
    btn_pause = 1'b1;
    btn_step  = 1'b1;
    wait_cyc(q + 19);
    chk("both_paused_before", paused, 1);
    wait_cyc(q + 20);
    chk("both_run", paused, 0);
    wait_cyc(q + 30);
    chk("both_no_step", paused, 0);
    btn_pause = 1'b0;
    btn_step  = 1'b0;
    wait_cyc(q + 70);
    btn_step = 1'b1;
    wait_cyc(q + 100);
    btn_step = 1'b0;
    chk("run_step_ignored", paused, 0);
    wait_cyc(q + 140);
    chk("final_count", cycle_count, 19);
    chk("final_paused", paused, 0);
    chk("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Upstream clock-control stage for the Nexys4 top level. It replaces the free-running divider and level-sensitive PAUSE. It debounces the raw PAUSE and STEP push buttons, runs a run / pause / single-step state machine, and produces the divided processor clock that feeds Wrapper. It also produces a one-cycle tick per processor clock and a processor cycle count for the seven-segment path.

Parameters:
CLK_DIV_BITS, 25, divider MSB index; CPU clock period = 2^(CLK_DIV_BITS+1) CLK_undiv cycles; legal range 1..26.
DEBOUNCE_BITS, 20, button filter length = 2^DEBOUNCE_BITS stable cycles (~10 ms at 100 MHz).
START_PAUSED, 0, 1 = leave reset in PAUSED, 0 = leave reset in RUN.

Ports:
CLK_undiv  input  1  100 MHz board clock; every register in this block is clocked by it.
RESET  input  1  asynchronous, active-high reset.
BTN_PAUSE  input  1  raw, unsynchronised pause button (BTNU); each press toggles run/pause.
BTN_STEP  input  1  raw, unsynchronised step button (BTNC); each press gives one CPU clock period while paused.
CLK_CPU  output  1  divided processor clock; driven directly from a register bit, glitch-free.
CPU_TICK  output  1  one CLK_undiv-cycle pulse coincident with each CLK_CPU rising edge.
PAUSED  output  1  high in PAUSED state only.
CYCLE_COUNT  output  32  number of CLK_CPU rising edges since reset; wraps 0xFFFFFFFF -> 0.

Behaviour:
- Reset (async): all registers cleared.
  - cnt = 0, so CLK_CPU = 0.
  - CPU_TICK = 0, CYCLE_COUNT = 0, debouncer state = released.
  - State = PAUSED if START_PAUSED else RUN; PAUSED output follows the state.
  - Reset asserted mid-step or mid-drain aborts it immediately.
- Debouncer (one per button):
  - Two-flop synchroniser feeds a filter counter.
  - The counter increments while the synced value differs from the stable value, and clears when they match.
  - When the counter reaches 2^DEBOUNCE_BITS-1 with a mismatch still present, stable <= synced and the counter clears.
  - press_evt = registered rising edge of stable: a one-cycle pulse.
  - Latency from a clean raw rise to press_evt = 2^DEBOUNCE_BITS + 3 cycles.
  - Glitches shorter than 2^DEBOUNCE_BITS cycles produce no event.
  - Release is filtered the same way and produces no event.
- Divider: cnt is CLK_DIV_BITS+1 bits wide; CLK_CPU = cnt[MSB].
  - cnt increments by 1 in RUN, DRAIN and STEP; it is held at 0 in PAUSED.
  - CPU_TICK and the CYCLE_COUNT increment occur on the edge where cnt goes from 0111..1 to 1000..0, while counting.
- FSM states: RUN, DRAIN, PAUSED, STEP.
  - RUN: pause_evt -> DRAIN; step_evt ignored.
  - DRAIN (finish the current CPU period so no high phase is truncated): on the edge where cnt wraps all-ones -> 0, go to PAUSED. pause_evt -> RUN (cancel). step_evt ignored.
  - PAUSED: pause_evt -> RUN; step_evt -> STEP. Counting resumes from cnt = 0 in both cases.
  - STEP: runs exactly one full period, 2^(CLK_DIV_BITS+1) cycles, giving exactly one CPU_TICK. On wrap to 0 it returns to PAUSED. pause_evt -> RUN (continue without a gap). step_evt ignored.
  - pause_evt and step_evt in the same cycle: pause_evt wins and step_evt is discarded.
  - A wrap and pause_evt in the same cycle in DRAIN: pause_evt wins and the state becomes RUN.
- CLK_CPU is 0 whenever the state is PAUSED.
- PAUSED = (state == PAUSED), registered.
- No combinational path exists from the button inputs to any output.

Test Plan:
(Bench parameters: CLK_DIV_BITS=2 (period 8), DEBOUNCE_BITS=4, START_PAUSED=0.)
1. Reset release, no buttons:
   - CLK_CPU rises 4 cycles after reset release, then toggles every 4 cycles.
   - CPU_TICK is high exactly at each rise.
   - CYCLE_COUNT = 10 after 80 cycles.
2. Clean BTN_PAUSE press at cnt=5 (state RUN):
   - press_evt fires 19 cycles after the raw rise.
   - DRAIN continues until cnt wraps to 0, then PAUSED=1, CLK_CPU=0 and CYCLE_COUNT freezes.
3. Bounce rejection: BTN_PAUSE toggled with 10-cycle pulses for 100 cycles, then released:
   - no state change, PAUSED stays 0.
4. In PAUSED, one BTN_STEP press:
   - exactly one CPU_TICK.
   - CLK_CPU is high for 4 cycles.
   - 8 cycles after leaving PAUSED, the state returns to PAUSED with CYCLE_COUNT +1.
   - A second step press held across this period causes no extra tick.
5. Simultaneous clean PAUSE and STEP presses while PAUSED:
   - state goes to RUN; no single-step occurs.
   - A later STEP press in RUN is ignored.
6. RESET pulsed mid-STEP (cnt=6):
   - CLK_CPU=0 and CYCLE_COUNT=0 immediately (asynchronous).
   - After release the state is RUN, with the first CPU_TICK 4 cycles later.
